// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types, default parameters and counter-width helper for the I2S transceiver
package i2s_pkg;

    typedef enum logic {
        FMT_I2S = 1'b0,
        FMT_LJ  = 1'b1
    } fmt_e;

    localparam int DEF_SAMPLE_W  = 24;
    localparam int DEF_SLOT_W    = 32;
    localparam int DEF_MCLK_DIV  = 4;
    localparam int DEF_BCLK_HALF = 8;

    // Width of a counter running 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/i2s_codec_if_if.sv
// rtl/i2s_codec_if_if.sv - sample-side valid/ready bundle between the sampler datapath and the I2S transceiver
interface i2s_codec_if_if #(
    parameter int SAMPLE_W = i2s_pkg::DEF_SAMPLE_W
) ();

    logic [SAMPLE_W-1:0] tx_l;
    logic [SAMPLE_W-1:0] tx_r;
    logic                tx_valid;
    logic                tx_ready;
    logic [SAMPLE_W-1:0] rx_l;
    logic [SAMPLE_W-1:0] rx_r;
    logic                rx_valid;
    logic                tx_underrun;
    logic                frame_start;

    modport master (
        output tx_l, tx_r, tx_valid,
        input  tx_ready, rx_l, rx_r, rx_valid, tx_underrun, frame_start
    );

    modport slave (
        input  tx_l, tx_r, tx_valid,
        output tx_ready, rx_l, rx_r, rx_valid, tx_underrun, frame_start
    );

endinterface

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - MCLK/BCLK/LRCLK generation, bit position and edge strobes
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int SLOT_W    = DEF_SLOT_W,
    parameter int MCLK_DIV  = DEF_MCLK_DIV,
    parameter int BCLK_HALF = DEF_BCLK_HALF,
    localparam int BW       = cnt_w(SLOT_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    output logic          mclk,
    output logic          bclk,
    output logic          lrclk,
    output logic          fall,
    output logic          rise,
    output logic          frame_start,
    output logic [BW-1:0] bit_cnt
);

    localparam int MW = cnt_w(MCLK_DIV);
    localparam int HW = cnt_w(BCLK_HALF);

    logic [MW-1:0] mclk_cnt;
    logic [HW-1:0] bclk_cnt;
    logic          bclk_q;
    logic          lrclk_q;
    logic [BW-1:0] bit_q;
    logic          tc;
    logic          slot_end;

    assign tc          = (bclk_cnt == HW'(BCLK_HALF - 1));
    assign slot_end    = (bit_q == BW'(SLOT_W - 1));
    // Strobes mark the clk edge at which bclk itself toggles.
    assign fall        = enable & tc & bclk_q;
    assign rise        = enable & tc & ~bclk_q;
    assign frame_start = fall & slot_end & lrclk_q;

    assign mclk    = mclk_cnt[MW-1];
    assign bclk    = bclk_q;
    assign lrclk   = lrclk_q;
    assign bit_cnt = bit_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mclk_cnt <= '0;
        end else begin
            mclk_cnt <= mclk_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bclk_cnt <= '0;
            bclk_q   <= 1'b0;
            bit_q    <= '0;
            lrclk_q  <= 1'b0;
        end else if (!enable) begin
            bclk_cnt <= '0;
            bclk_q   <= 1'b0;
            bit_q    <= '0;
            lrclk_q  <= 1'b0;
        end else begin
            bclk_cnt <= tc ? '0 : bclk_cnt + 1'b1;
            if (tc) begin
                bclk_q <= ~bclk_q;
            end
            if (fall) begin
                bit_q <= slot_end ? '0 : bit_q + 1'b1;
                if (slot_end) begin
                    lrclk_q <= ~lrclk_q;
                end
            end
        end
    end

endmodule

// File: rtl/i2s_codec_if.sv
// rtl/i2s_codec_if.sv - I2S master transceiver: TX holding register and shifter, RX synchroniser and capture
module i2s_codec_if
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W  = DEF_SAMPLE_W,
    parameter int SLOT_W    = DEF_SLOT_W,
    parameter int MCLK_DIV  = DEF_MCLK_DIV,
    parameter int BCLK_HALF = DEF_BCLK_HALF
) (
    input  logic           Clk,
    input  logic           Reset_h,
    input  logic           enable,
    input  logic           fmt_lj,
    input  logic           loopback,
    output logic           codec_mclk,
    output logic           codec_bclk,
    output logic           codec_lrclk,
    output logic           codec_dout,
    input  logic           codec_din,
    i2s_codec_if_if.slave  smp
);

    localparam int BW  = cnt_w(SLOT_W);
    localparam int FW  = 2 * SLOT_W;
    localparam int PAD = SLOT_W - SAMPLE_W;

    logic          fall;
    logic          rise;
    logic          frame_start;
    logic [BW-1:0] bit_cnt;

    i2s_clkgen #(
        .SLOT_W    (SLOT_W),
        .MCLK_DIV  (MCLK_DIV),
        .BCLK_HALF (BCLK_HALF)
    ) u_clkgen (
        .clk         (Clk),
        .rst         (Reset_h),
        .enable      (enable),
        .mclk        (codec_mclk),
        .bclk        (codec_bclk),
        .lrclk       (codec_lrclk),
        .fall        (fall),
        .rise        (rise),
        .frame_start (frame_start),
        .bit_cnt     (bit_cnt)
    );

    logic                hold_full;
    logic [SAMPLE_W-1:0] hold_l;
    logic [SAMPLE_W-1:0] hold_r;

    always_ff @(posedge Clk or posedge Reset_h) begin
        if (Reset_h) begin
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
        end else if (frame_start && hold_full) begin
            hold_full <= 1'b0;
        end else if (smp.tx_valid && !hold_full) begin
            hold_full <= 1'b1;
            hold_l    <= smp.tx_l;
            hold_r    <= smp.tx_r;
        end
    end

    logic [SAMPLE_W-1:0] data_l;
    logic [SAMPLE_W-1:0] data_r;
    logic [SLOT_W-1:0]   slot_l;
    logic [SLOT_W-1:0]   slot_r;
    logic [FW-1:0]       frame;
    logic [FW-1:0]       tx_sh;
    logic                dout_q;
    fmt_e                fmt_q;

    // Whole frame is built at frame_start; I2S adds the one-bit delay by shifting the slot right.
    always_comb begin
        data_l = hold_full ? hold_l : '0;
        data_r = hold_full ? hold_r : '0;
        slot_l = {data_l, {PAD{1'b0}}};
        slot_r = {data_r, {PAD{1'b0}}};
        if (!fmt_lj) begin
            slot_l = slot_l >> 1;
            slot_r = slot_r >> 1;
        end
        frame = {slot_l, slot_r};
    end

    always_ff @(posedge Clk or posedge Reset_h) begin
        if (Reset_h) begin
            tx_sh  <= '0;
            dout_q <= 1'b0;
            fmt_q  <= FMT_I2S;
        end else if (!enable) begin
            tx_sh  <= '0;
            dout_q <= 1'b0;
        end else if (frame_start) begin
            dout_q <= frame[FW-1];
            tx_sh  <= {frame[FW-2:0], 1'b0};
            fmt_q  <= fmt_lj ? FMT_LJ : FMT_I2S;
        end else if (fall) begin
            dout_q <= tx_sh[FW-1];
            tx_sh  <= {tx_sh[FW-2:0], 1'b0};
        end
    end

    logic [1:0]          din_sync;
    logic [BW-1:0]       first_bit;
    logic [BW-1:0]       last_bit;
    logic                in_data;
    logic [SAMPLE_W-2:0] rx_sh;
    logic [SAMPLE_W-1:0] rx_word;
    logic [SAMPLE_W-1:0] rx_stage;
    logic [SAMPLE_W-1:0] rx_l_q;
    logic [SAMPLE_W-1:0] rx_r_q;
    logic                rx_pend;
    logic                rx_valid_q;

    always_ff @(posedge Clk or posedge Reset_h) begin
        if (Reset_h) begin
            din_sync <= '0;
        end else begin
            din_sync <= {din_sync[0], codec_din};
        end
    end

    always_comb begin
        first_bit = (fmt_q == FMT_LJ) ? '0 : BW'(1);
        last_bit  = (fmt_q == FMT_LJ) ? BW'(SAMPLE_W - 1) : BW'(SAMPLE_W);
        in_data   = (bit_cnt >= first_bit) && (bit_cnt <= last_bit);
        rx_word   = {rx_sh, din_sync[1]};
    end

    always_ff @(posedge Clk or posedge Reset_h) begin
        if (Reset_h) begin
            rx_sh      <= '0;
            rx_stage   <= '0;
            rx_l_q     <= '0;
            rx_r_q     <= '0;
            rx_pend    <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= rx_pend;
            rx_pend    <= 1'b0;
            if (!enable) begin
                rx_sh    <= '0;
                rx_stage <= '0;
            end else if (rise && in_data) begin
                rx_sh <= rx_word[SAMPLE_W-2:0];
                if (bit_cnt == last_bit) begin
                    if (!codec_lrclk) begin
                        rx_stage <= rx_word;
                    end else begin
                        rx_l_q  <= rx_stage;
                        rx_r_q  <= rx_word;
                        rx_pend <= 1'b1;
                    end
                end
            end
        end
    end

    assign codec_dout      = loopback ? codec_din : dout_q;
    assign smp.tx_ready    = ~hold_full;
    assign smp.tx_underrun = frame_start & ~hold_full;
    assign smp.frame_start = frame_start;
    assign smp.rx_l        = rx_l_q;
    assign smp.rx_r        = rx_r_q;
    assign smp.rx_valid    = rx_valid_q;

endmodule

// File: tb/tb_i2s_codec_if.sv
// tb/tb_i2s_codec_if.sv - directed self-checking bench for i2s_codec_if
module tb_i2s_codec_if;

    logic Clk = 1'b0;
    logic Reset_h;
    logic enable;
    logic fmt_lj;
    logic loopback;
    logic codec_mclk;
    logic codec_bclk;
    logic codec_lrclk;
    logic codec_dout;
    logic codec_din;
    logic man_din;
    logic model_en;
    logic model_din = 1'b0;
    logic m_prev_b = 1'b0;
    logic m_prev_lr = 1'b0;
    int   m_idx = 0;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    i2s_codec_if_if #(.SAMPLE_W(24)) smp ();

    i2s_codec_if #(
        .SAMPLE_W  (24),
        .SLOT_W    (32),
        .MCLK_DIV  (4),
        .BCLK_HALF (8)
    ) dut (
        .Clk         (Clk),
        .Reset_h     (Reset_h),
        .enable      (enable),
        .fmt_lj      (fmt_lj),
        .loopback    (loopback),
        .codec_mclk  (codec_mclk),
        .codec_bclk  (codec_bclk),
        .codec_lrclk (codec_lrclk),
        .codec_dout  (codec_dout),
        .codec_din   (codec_din),
        .smp         (smp)
    );

    assign codec_din = model_en ? model_din : man_din;

    // ADC model: I2S slave sending L=0x800001, R=0x7FFFFF, one bit per BCLK fall.
    function automatic logic mbit(input int idx, input logic lr);
        logic [23:0] w;
        w = lr ? 24'h7FFFFF : 24'h800001;
        if (idx >= 1 && idx <= 24) return w[24-idx];
        return 1'b0;
    endfunction

    always @(negedge Clk) begin
        if (m_prev_b && !codec_bclk) begin
            if (codec_lrclk != m_prev_lr) begin
                m_idx     <= 0;
                model_din <= 1'b0;
            end else begin
                m_idx     <= m_idx + 1;
                model_din <= mbit(m_idx + 1, codec_lrclk);
            end
            m_prev_lr <= codec_lrclk;
        end
        m_prev_b <= codec_bclk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return codec_mclk;
            1:       return codec_bclk;
            2:       return codec_lrclk;
            default: return smp.frame_start;
        endcase
    endfunction

    task automatic measure(input int sel, output int period);
        int   first;
        logic prev;
        period = -1;
        first  = -1;
        prev   = sig(sel);
        for (int i = 0; i < 4000; i++) begin
            @(negedge Clk);
            if (sig(sel) && !prev) begin
                if (first < 0) first = i;
                else begin
                    period = i - first;
                    break;
                end
            end
            prev = sig(sel);
        end
    endtask

    task automatic wait_fs(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            if (smp.frame_start) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, ok, 1);
    endtask

    task automatic collect_frame(input string tag, output logic [63:0] bits,
                                 output logic rdy_fs, output logic rdy_next, output logic uf);
        logic prev;
        int   n;
        wait_fs(tag);
        rdy_fs   = smp.tx_ready;
        uf       = smp.tx_underrun;
        rdy_next = 1'b0;
        prev     = codec_bclk;
        bits     = '0;
        n        = 0;
        for (int i = 0; i < 1100 && n < 64; i++) begin
            @(negedge Clk);
            if (i == 0) rdy_next = smp.tx_ready;
            if (prev && !codec_bclk) begin
                bits = {bits[62:0], codec_dout};
                n++;
            end
            prev = codec_bclk;
        end
    endtask

    task automatic push(input logic [23:0] l, input logic [23:0] r);
        @(negedge Clk);
        smp.tx_l     = l;
        smp.tx_r     = r;
        smp.tx_valid = 1'b1;
        @(negedge Clk);
        smp.tx_valid = 1'b0;
    endtask

    initial begin
        int          p;
        int          n_uf;
        int          n_fs;
        int          n_one;
        int          n_mis;
        int          n_rv;
        logic [63:0] bits;
        logic        rdy_fs;
        logic        rdy_next;
        logic        uf;

        Reset_h      = 1'b1;
        enable       = 1'b0;
        fmt_lj       = 1'b0;
        loopback     = 1'b0;
        man_din      = 1'b0;
        model_en     = 1'b0;
        smp.tx_valid = 1'b0;
        smp.tx_l     = '0;
        smp.tx_r     = '0;
        repeat (3) @(negedge Clk);

        chk("reset_outputs", {codec_mclk, codec_bclk, codec_lrclk, codec_dout, smp.rx_valid,
                              smp.tx_underrun, smp.frame_start, smp.tx_ready}, 8'b0000_0001);
        chk("reset_rx", {smp.rx_l, smp.rx_r}, 48'h0);

        Reset_h = 1'b0;
        enable  = 1'b1;
        measure(0, p);  chk("mclk_period", p, 4);
        measure(1, p);  chk("bclk_period", p, 16);
        measure(2, p);  chk("lrclk_period", p, 1024);
        measure(3, p);  chk("frame_start_interval", p, 1024);

        wait_fs("fs_sync_i2s");
        push(24'hA5A5A5, 24'h123456);
        chk("tx_ready_held", smp.tx_ready, 0);
        collect_frame("fs_i2s", bits, rdy_fs, rdy_next, uf);
        chk("i2s_frame", bits, 64'h52D2D280_091A2B00);
        chk("tx_ready_at_fs", rdy_fs, 0);
        chk("tx_ready_after_fs", rdy_next, 1);
        chk("no_underrun_i2s", uf, 0);

        fmt_lj = 1'b1;
        push(24'hA5A5A5, 24'h123456);
        collect_frame("fs_lj", bits, rdy_fs, rdy_next, uf);
        chk("lj_frame", bits, 64'hA5A5A500_12345600);
        chk("no_underrun_lj", uf, 0);

        wait_fs("fs_sync_underrun");
        n_uf = 0; n_fs = 0; n_one = 0; n_mis = 0;
        for (int i = 0; i < 3072; i++) begin
            @(negedge Clk);
            if (smp.tx_underrun) n_uf++;
            if (smp.frame_start) n_fs++;
            if (codec_dout) n_one++;
            if (smp.tx_underrun != smp.frame_start) n_mis++;
        end
        chk("underrun_count", n_uf, 3);
        chk("underrun_fs_count", n_fs, 3);
        chk("underrun_dout_ones", n_one, 0);
        chk("underrun_align", n_mis, 0);

        fmt_lj   = 1'b0;
        model_en = 1'b1;
        wait_fs("fs_rx_a");
        wait_fs("fs_rx_b");
        n_rv = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge Clk);
            if (smp.rx_valid) n_rv++;
        end
        chk("rx_valid_per_frame", n_rv, 1);
        chk("rx_l", smp.rx_l, 24'h800001);
        chk("rx_r", smp.rx_r, 24'h7FFFFF);

        model_en = 1'b0;
        push(24'h111111, 24'h222222);
        chk("hold_full_before_reset", smp.tx_ready, 0);
        for (int i = 0; i < 1100 && !codec_lrclk; i++) @(negedge Clk);
        repeat (40) @(negedge Clk);
        chk("in_right_slot", codec_lrclk, 1);
        Reset_h = 1'b1;
        #1;
        chk("midframe_reset_outputs", {codec_mclk, codec_bclk, codec_lrclk, codec_dout, smp.rx_valid,
                                       smp.tx_underrun, smp.frame_start, smp.tx_ready}, 8'b0000_0001);
        chk("midframe_reset_rx", {smp.rx_l, smp.rx_r}, 48'h0);
        @(negedge Clk);
        Reset_h = 1'b0;
        wait_fs("fs_after_reset");
        chk("held_pair_discarded", smp.tx_underrun, 1);

        loopback = 1'b1;
        man_din  = 1'b1; #1; chk("loopback_1a", codec_dout, 1);
        man_din  = 1'b0; #1; chk("loopback_0", codec_dout, 0);
        man_din  = 1'b1; #1; chk("loopback_1b", codec_dout, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
